// File: rtl/time_set_ctrl.sv
// Time-set sequencer for the clock counter: RUN -> SET_HOUR -> SET_MIN -> COMMIT -> RUN.
// Optional set-mode inactivity abort is built when TIME_SET_TIMEOUT_EN is defined.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// S_RUN      | clock counter running, buttons other than btn_mode ignored
// S_SET_HOUR | shadow hour edited by btn_inc, hour digits blink
// S_SET_MIN  | shadow minute edited by btn_inc, minute digits blink
// S_COMMIT   | single cycle, load strobe carries the shadow values out
module time_set_ctrl #(
   parameter int TIMEOUT_TICKS = 30
) (
   input  logic       clk,
   input  logic       RESET,
   input  logic       tick_1hz,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic [5:0] cur_hour,
   input  logic [5:0] cur_min,
   output logic       run_en,
   output logic       load,
   output logic [5:0] data_hour,
   output logic [5:0] data_min,
   output logic [3:0] digit_blank,
   output logic       set_active
);

   typedef enum logic [1:0] {
      S_RUN      = 2'd0,
      S_SET_HOUR = 2'd1,
      S_SET_MIN  = 2'd2,
      S_COMMIT   = 2'd3
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [5:0] shadow_hour;
   logic [5:0] shadow_min;
   logic [5:0] hour_nxt;
   logic [5:0] min_nxt;
   logic [5:0] hour_inc;
   logic [5:0] min_inc;
   logic       blink;
   logic       blink_nxt;
   logic [3:0] blank_nxt;
   logic       in_set;
   logic       to_expire;

   // Out-of-range captured values fall into the >= branch and wrap to zero.
   assign hour_inc = (shadow_hour >= 6'd23) ? 6'd0 : shadow_hour + 6'd1;
   assign min_inc  = (shadow_min  >= 6'd59) ? 6'd0 : shadow_min  + 6'd1;
   assign in_set   = (state == S_SET_HOUR) || (state == S_SET_MIN);

`ifdef TIME_SET_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_TICKS + 1);

   logic [CNT_W-1:0] to_cnt;

   assign to_expire = in_set && tick_1hz && !btn_mode && !btn_inc &&
                      (to_cnt == CNT_W'(TIMEOUT_TICKS - 1));

   always_ff @(posedge clk) begin
      if (RESET || (state == S_RUN) || btn_mode || btn_inc) begin
         to_cnt <= '0;
      end else if (in_set && tick_1hz) begin
         to_cnt <= to_expire ? '0 : to_cnt + CNT_W'(1);
      end
   end
`else
   logic unused_timeout;

   assign to_expire      = 1'b0;
   assign unused_timeout = (TIMEOUT_TICKS == 0);
`endif

   always_comb begin
      state_nxt = state;
      hour_nxt  = shadow_hour;
      min_nxt   = shadow_min;
      blink_nxt = blink;
      unique case (state)
         S_RUN: begin
            if (btn_mode) begin
               state_nxt = S_SET_HOUR;
               hour_nxt  = cur_hour;
               min_nxt   = cur_min;
               blink_nxt = 1'b0;
            end
         end
         S_SET_HOUR: begin
            if (btn_mode) begin
               state_nxt = S_SET_MIN;
               blink_nxt = 1'b0;
            end else if (to_expire) begin
               state_nxt = S_RUN;
            end else begin
               if (btn_inc)  hour_nxt  = hour_inc;
               if (tick_1hz) blink_nxt = ~blink;
            end
         end
         S_SET_MIN: begin
            if (btn_mode) begin
               state_nxt = S_COMMIT;
               blink_nxt = 1'b0;
            end else if (to_expire) begin
               state_nxt = S_RUN;
            end else begin
               if (btn_inc)  min_nxt   = min_inc;
               if (tick_1hz) blink_nxt = ~blink;
            end
         end
         S_COMMIT: state_nxt = S_RUN;
         default:  state_nxt = S_RUN;
      endcase

      blank_nxt = 4'b0000;
      if (blink_nxt && (state_nxt == S_SET_HOUR)) blank_nxt = 4'b1100;
      if (blink_nxt && (state_nxt == S_SET_MIN))  blank_nxt = 4'b0011;
   end

   // Outputs are registered from next-state values so they line up with state.
   always_ff @(posedge clk) begin
      if (RESET) begin
         state       <= S_RUN;
         shadow_hour <= 6'd0;
         shadow_min  <= 6'd0;
         blink       <= 1'b0;
         run_en      <= 1'b1;
         load        <= 1'b0;
         digit_blank <= 4'b0000;
         set_active  <= 1'b0;
      end else begin
         state       <= state_nxt;
         shadow_hour <= hour_nxt;
         shadow_min  <= min_nxt;
         blink       <= blink_nxt;
         run_en      <= (state_nxt == S_RUN);
         load        <= (state_nxt == S_COMMIT);
         digit_blank <= blank_nxt;
         set_active  <= (state_nxt == S_SET_HOUR) || (state_nxt == S_SET_MIN);
      end
   end

   assign data_hour = shadow_hour;
   assign data_min  = shadow_min;

endmodule
